// File: rtl/piso_serializer_if.sv
// -----------------------------------------------------------------------------
// piso_serializer_if
// Bundles the load handshake and serial output of piso_serializer.
//   load_valid  : source presents a word on load_data
//   load_data   : WIDTH-bit word to serialize (sampled only on handshake)
//   load_ready  : serializer can accept a word (high only when idle)
//   sout        : serial data bit, MSB first
//   sout_valid  : sout carries a data or parity bit this cycle
//   done        : one-cycle pulse in the first idle cycle after a word
// Modports: master = word source / serial sink, slave = the serializer.
// -----------------------------------------------------------------------------
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             sout;
    logic             sout_valid;
    logic             done;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  sout,
        input  sout_valid,
        input  done
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output sout,
        output sout_valid,
        output done
    );
endinterface

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Parallel-in serial-out serializer. Accepts a WIDTH-bit word over a
// valid/ready handshake while idle and shifts it out MSB first, one bit per
// clock, with sout_valid qualifying each bit and a registered done pulse in
// the first idle cycle after the word.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-low reset
//   bus    : piso_serializer_if.slave (load_valid/load_data/load_ready,
//            sout/sout_valid/done)
//
// Build option: define PISO_PARITY_EN to append one even-parity bit (XOR of
// the loaded word) after the data bits; done then follows the parity bit.
//
// All outputs are decoded from registered state only; nothing on the output
// side depends combinationally on load_valid or load_data.
// -----------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    piso_serializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             done_q,  done_d;
`ifdef PISO_PARITY_EN
    logic             parity_q, parity_d;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        cnt_d          = cnt_q;
        done_d         = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d       = parity_q;
`endif
        bus.load_ready = 1'b0;
        bus.sout       = 1'b0;
        bus.sout_valid = 1'b0;
        bus.done       = done_q;

        case (state_q)
            ST_IDLE: begin
                bus.load_ready = 1'b1;
                if (bus.load_valid) begin
                    shift_d  = bus.load_data;
                    cnt_d    = CW'(WIDTH - 1);
`ifdef PISO_PARITY_EN
                    // Parity is taken from the word as loaded, since the
                    // shift register is zero-filled while streaming.
                    parity_d = ^bus.load_data;
`endif
                    state_d  = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                bus.sout       = shift_q[WIDTH-1];
                bus.sout_valid = 1'b1;
                shift_d        = {shift_q[WIDTH-2:0], 1'b0};
                // Counter value 0 marks the final bit; leave the state rather
                // than decrementing so the counter can never wrap.
                if (cnt_q == '0) begin
`ifdef PISO_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                bus.sout       = parity_q;
                bus.sout_valid = 1'b1;
                state_d        = ST_IDLE;
                done_d         = 1'b1;
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
// Drives an 8-bit serializer with directed and random traffic and compares it
// every cycle against a queue-based reference: a handshake enqueues the word's
// bits MSB first (plus parity when PISO_PARITY_EN is defined), each later
// cycle dequeues one bit, and done follows the cycle the queue empties.
// A second 2-bit instance covers the narrowest width.
// -----------------------------------------------------------------------------
module tb_piso_serializer;
    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = W + PAR;

    bit   clk;
    logic rst_n;
    logic rst2_n;
    int   vectors     = 0;
    int   miscompares = 0;
    bit   chk_on      = 0;

    piso_serializer_if #(.WIDTH(W)) bus ();
    piso_serializer_if #(.WIDTH(2)) bus2 ();

    piso_serializer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    piso_serializer #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .reset (rst2_n),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit exp_q[$];
    bit exp_done = 1'b0;

    always @(posedge clk) begin
        if (rst_n !== 1'b1) begin
            exp_q.delete();
            exp_done = 1'b0;
        end else if (exp_q.size() == 0) begin
            exp_done = 1'b0;
            if (bus.load_valid === 1'b1) begin
                for (int i = W - 1; i >= 0; i--) exp_q.push_back(bus.load_data[i]);
                if (PAR == 1) exp_q.push_back(^bus.load_data);
            end
        end else begin
            void'(exp_q.pop_front());
            exp_done = (exp_q.size() == 0);
        end
    end

    initial begin
        @(posedge clk);
        chk_on = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_ready", 32'(bus.load_ready), 32'(exp_q.size() == 0));
            check("model_valid", 32'(bus.sout_valid), 32'(exp_q.size() != 0));
            check("model_sout",  32'(bus.sout),       32'((exp_q.size() != 0) ? exp_q[0] : 1'b0));
            check("model_done",  32'(bus.done),       32'(exp_done));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic r, input logic v, input logic [W-1:0] d);
        rst_n          = r;
        bus.load_valid = v;
        bus.load_data  = d;
        @(negedge clk);
    endtask

    task automatic drive2(input logic r, input logic v, input logic [1:0] d);
        rst2_n          = r;
        bus2.load_valid = v;
        bus2.load_data  = d;
        @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic s, input logic v,
                              input logic rdy, input logic dn);
        check({name, "_sout"},  32'(bus.sout),       32'(s));
        check({name, "_valid"}, 32'(bus.sout_valid), 32'(v));
        check({name, "_ready"}, 32'(bus.load_ready), 32'(rdy));
        check({name, "_done"},  32'(bus.done),       32'(dn));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] seq;
        logic [W-1:0] s1;
        logic [W-1:0] s2;
        logic         all_v;
        logic         any_done;
        logic         any_valid;

        rst_n = 1'b0;  bus.load_valid = 1'b1;  bus.load_data = 8'h5A;
        rst2_n = 1'b0; bus2.load_valid = 1'b0; bus2.load_data = 2'b00;

        // Reset held low with load_valid high: nothing accepted.
        drive(1'b0, 1'b1, 8'h5A);
        drive(1'b0, 1'b1, 8'h5A);
        expect_out("reset", 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 8'h00);
        expect_out("post_reset", 1'b0, 1'b0, 1'b1, 1'b0);

        // Single word 8'hA5, with load_data/load_valid churning while busy.
        seq = 8'b1010_0101;
        drive(1'b1, 1'b1, 8'hA5);
        check("pin_model_len", 32'(exp_q.size()), 32'(NB));
        expect_out("a5_b0", seq[7], 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < W; i++) begin
            drive(1'b1, i[0], 8'h00);
            expect_out("a5_bit", seq[7-i], 1'b1, 1'b0, 1'b0);
        end
`ifdef PISO_PARITY_EN
        drive(1'b1, 1'b1, 8'h00);
        expect_out("a5_par", 1'b0, 1'b1, 1'b0, 1'b0);
`endif
        drive(1'b1, 1'b0, 8'h00);
        expect_out("a5_done", 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 8'h00);
        expect_out("a5_after", 1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back: FF then 01 with load_valid held high.
        all_v = 1'b1;
        drive(1'b1, 1'b1, 8'hFF);
        s1[W-1] = bus.sout; all_v &= bus.sout_valid;
        for (int i = 1; i < W; i++) begin
            drive(1'b1, 1'b1, 8'hFF);
            s1[W-1-i] = bus.sout; all_v &= bus.sout_valid;
        end
`ifdef PISO_PARITY_EN
        drive(1'b1, 1'b1, 8'hFF);
        expect_out("ff_par", 1'b0, 1'b1, 1'b0, 1'b0);
`endif
        drive(1'b1, 1'b1, 8'hFF);
        expect_out("b2b_gap", 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 8'h01);
        s2[W-1] = bus.sout; all_v &= bus.sout_valid;
        for (int i = 1; i < W; i++) begin
            drive(1'b1, 1'b0, 8'hFF);
            s2[W-1-i] = bus.sout; all_v &= bus.sout_valid;
        end
        check("b2b_word1", 32'(s1), 32'h0000_00FF);
        check("b2b_word2", 32'(s2), 32'h0000_0001);
        check("b2b_valid", 32'(all_v), 32'h1);
`ifdef PISO_PARITY_EN
        drive(1'b1, 1'b0, 8'h00);
        expect_out("01_par", 1'b1, 1'b1, 1'b0, 1'b0);
`endif
        drive(1'b1, 1'b0, 8'h00);
        expect_out("b2b_done", 1'b0, 1'b0, 1'b1, 1'b1);

        // Reset after three bits of 8'hC3: word dropped, no done ever.
        drive(1'b1, 1'b1, 8'hC3);
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        expect_out("c3_b2", 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00);
        expect_out("midrst", 1'b0, 1'b0, 1'b1, 1'b0);
        any_done = 1'b0; any_valid = 1'b0;
        for (int i = 0; i < NB + 3; i++) begin
            drive(1'b1, 1'b0, 8'h00);
            any_done |= bus.done; any_valid |= bus.sout_valid;
        end
        check("midrst_nodone",  32'(any_done),  32'h0);
        check("midrst_novalid", 32'(any_valid), 32'h0);

        // Random traffic, occasional resets, checked by the model.
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 2) != 0), W'($urandom));
        end
        for (int n = 0; n < NB + 2; n++) drive(1'b1, 1'b0, 8'h00);

        // WIDTH = 2 instance: 2'b10.
        drive2(1'b0, 1'b0, 2'b00);
        drive2(1'b1, 1'b1, 2'b10);
        check("w2_b0",   32'(bus2.sout),       32'h1);
        check("w2_v0",   32'(bus2.sout_valid), 32'h1);
        drive2(1'b1, 1'b0, 2'b00);
        check("w2_b1",   32'(bus2.sout),       32'h0);
        check("w2_v1",   32'(bus2.sout_valid), 32'h1);
`ifdef PISO_PARITY_EN
        drive2(1'b1, 1'b0, 2'b00);
        check("w2_par",  32'(bus2.sout),       32'h1);
        check("w2_pv",   32'(bus2.sout_valid), 32'h1);
`endif
        drive2(1'b1, 1'b0, 2'b00);
        check("w2_done", 32'(bus2.done),       32'h1);
        check("w2_rdy",  32'(bus2.load_ready), 32'h1);
        check("w2_idle", 32'(bus2.sout_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive2(1'b1, 1'b0, 2'b00);
            check("w2_nowrap_valid", 32'(bus2.sout_valid), 32'h0);
            check("w2_nowrap_done",  32'(bus2.done),       32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
